rx_intf_m_axis_fifo_tx: RTL

Downstream stage of the rx DMA header/packet scheduler. Buffers the 64-bit words it emits in a first-word-fall-through FIFO and drives them as one AXI-Stream packet toward the Xilinx AXI DMA S2MM port. Each packet is triggered by `start_1trans` and sized by `num_dma_symbol`, and the block generates `m_axis_tlast` on the final beat. It also implements the scheduler's flush (`m_axis_rst`) and fake-tlast recovery (`m_axis_tlast_auto_recover`) requests.

---
 rtl/rx_intf_m_axis_fifo_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rx_intf_m_axis_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module   : rx_intf_m_axis_fifo_tx
// Brief    : FWFT word FIFO feeding one AXI-Stream packet per start pulse,
//            with flush and fake-tlast recovery. Optional status counters
//            enabled by RX_INTF_M_AXIS_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rx_intf_m_axis_fifo_tx #(
    parameter int C_M_AXIS_TDATA_WIDTH   = 64,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int FIFO_ADDR_WIDTH        = 9
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   data_to_m_axis,
    input  logic                              data_ready_to_m_axis,
    input  logic                              start_1trans,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_dma_symbol,
    input  logic                              m_axis_rst,
    input  logic                              m_axis_tlast_auto_recover,
    output logic                              m_axis_tvalid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [FIFO_ADDR_WIDTH:0]          fifo_data_count,
    output logic                              fifo_overflow,
    output logic [15:0]                       overflow_cnt,
    output logic [15:0]                       pkt_cnt
);

    localparam int                              DEPTH   = 2 ** FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0]        PTR_ONE = 1;
    localparam logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_STREAM     = 2'd1,
        ST_FORCE_LAST = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   len_q, len_d;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   beat_cnt_q, beat_cnt_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH:0]            wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_WIDTH:0]            count;
    logic                                full, empty, push, pop, drop;
    logic                                overflow_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]     rd_word;

    // Extra pointer bit separates full (count = DEPTH) from empty (count = 0).
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = count[FIFO_ADDR_WIDTH];
    assign empty   = (count == '0);
    assign push    = data_ready_to_m_axis && !full && !m_axis_rst;
    assign drop    = data_ready_to_m_axis &&  full && !m_axis_rst;
    assign pop     = (state_q == ST_STREAM) && !empty && m_axis_tready;
    assign rd_word = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];

    assign fifo_data_count = count;
    assign fifo_overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= data_to_m_axis;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (m_axis_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_1trans && (num_dma_symbol != '0)) begin
                    len_d      = num_dma_symbol;
                    beat_cnt_d = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                m_axis_tvalid = !empty;
                m_axis_tlast  = (beat_cnt_q == len_q - LEN_ONE);
                // Gate the RAM word so an empty FIFO never shows stale data.
                m_axis_tdata  = empty ? '0 : rd_word;
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + LEN_ONE;
                    if (m_axis_tlast) state_d = ST_IDLE;
                end
            end
            ST_FORCE_LAST: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A pending fake tlast must still be delivered, so flush leaves it alone.
        if (m_axis_rst && (state_q != ST_FORCE_LAST)) state_d = ST_IDLE;
        if (m_axis_tlast_auto_recover)                state_d = ST_FORCE_LAST;
    end

`ifdef RX_INTF_M_AXIS_STATUS_EN
    logic [15:0] overflow_cnt_q;
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_cnt_q <= '0;
            pkt_cnt_q      <= '0;
        end else begin
            if (drop && (overflow_cnt_q != 16'hFFFF)) begin
                overflow_cnt_q <= overflow_cnt_q + 16'd1;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign overflow_cnt = overflow_cnt_q;
    assign pkt_cnt      = pkt_cnt_q;
`else
    assign overflow_cnt = '0;
    assign pkt_cnt      = '0;
`endif

endmodule
`default_nettype wire
